// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: CP0 register addresses, exception codes and field positions
package cp0_unit_pkg;
    localparam logic [7:0] CR_BADVADDR = 8'h40;
    localparam logic [7:0] CR_COUNT    = 8'h48;
    localparam logic [7:0] CR_COMPARE  = 8'h58;
    localparam logic [7:0] CR_STATUS   = 8'h60;
    localparam logic [7:0] CR_CAUSE    = 8'h68;
    localparam logic [7:0] CR_EPC      = 8'h70;
    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;
    localparam int ST_BEV = 22;
    localparam int ST_EXL = 1;
    localparam int ST_IE  = 0;
    localparam int CA_BD  = 31;
    localparam int CA_TI  = 30;
    function automatic logic is_addr_exc(input logic [4:0] c);
        return c == EX_ADEL || c == EX_ADES;
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count, Compare and the sticky timer interrupt TI
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    logic [PW-1:0] pre;
    logic tick;
    assign tick = pre == PW'(COUNT_DIV - 1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                pre   <= '0;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) count <= count + 32'd1;
            end
            if (compare_we) compare <= wdata;
            // a Compare write clears TI even if the match lands in the same cycle
            ti <= compare_we ? 1'b0 : ti | (tick & ~count_we & (count + 32'd1 == compare));
        end
    end
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 registers, exception/ERET commit, MTC0/MFC0 and interrupt request
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int          EXT_INT_W = 6,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] VEC_BEV1  = 32'hbfc00380,
    parameter logic [31:0] VEC_BEV0  = 32'h80000180
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic                 wb_valid,
    input  logic                 wb_ex,
    input  logic [4:0]           wb_exccode,
    input  logic                 wb_bd,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_badvaddr,
    input  logic                 wb_eret,
    input  logic                 mtc0_op,
    input  logic [7:0]           c0_addr,
    input  logic [31:0]          c0_wdata,
    output logic [31:0]          c0_rdata,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic                 has_int
);
    logic ex_c, eret_c, mtc0_we;
    logic bev, exl, ie, bd, ti;
    logic [7:0] im, ip;
    logic [5:0] ip_hw;
    logic [1:0] ip_sw;
    logic [4:0] exccode;
    logic [31:0] epc, badvaddr, count, compare;
    logic [EXT_INT_W-1:0] sync1, sync2;
    assign ex_c     = wb_valid & wb_ex;
    assign eret_c   = wb_valid & wb_eret & ~wb_ex;
    assign mtc0_we  = wb_valid & mtc0_op & ~wb_ex;
    assign ip       = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign flush    = ex_c | eret_c;
    assign flush_pc = eret_c ? epc : (bev ? VEC_BEV1 : VEC_BEV0);
    assign has_int  = |(ip & im) & ie & ~exl;
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_we && c0_addr == CR_COUNT),
        .compare_we (mtc0_we && c0_addr == CR_COMPARE),
        .wdata      (c0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1    <= '0;
            sync2    <= '0;
            ip_hw    <= '0;
            bev      <= 1'b1;
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip_sw    <= '0;
            exccode  <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            sync1 <= ext_int;
            sync2 <= sync1;
            ip_hw <= 6'(sync2);
            if (ex_c) begin
                exccode <= wb_exccode;
                exl     <= 1'b1;
                if (!exl) begin
                    bd  <= wb_bd;
                    epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
                end
                if (is_addr_exc(wb_exccode)) badvaddr <= wb_badvaddr;
            end else if (eret_c) begin
                exl <= 1'b0;
            end
            if (mtc0_we && c0_addr == CR_STATUS) begin
                bev <= c0_wdata[ST_BEV];
                im  <= c0_wdata[15:8];
                ie  <= c0_wdata[ST_IE];
                if (!eret_c) exl <= c0_wdata[ST_EXL];
            end
            if (mtc0_we && c0_addr == CR_CAUSE) ip_sw <= c0_wdata[9:8];
            if (mtc0_we && c0_addr == CR_EPC) epc <= c0_wdata;
        end
    end
    always_comb begin
        c0_rdata = c0_addr == CR_BADVADDR ? badvaddr :
                   c0_addr == CR_COUNT    ? count :
                   c0_addr == CR_COMPARE  ? compare :
                   c0_addr == CR_STATUS   ? {9'b0, bev, 6'b0, im, 6'b0, exl, ie} :
                   c0_addr == CR_CAUSE    ? {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0} :
                   c0_addr == CR_EPC      ? epc : 32'h0;
    end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scenario and randomized checks of cp0_unit against a rule-level model
module tb_cp0_unit;
    import cp0_unit_pkg::*;
    localparam int DIV = 2;
    localparam logic [31:0] V1 = 32'hbfc00380;
    localparam logic [31:0] V0 = 32'h80000180;
    logic clk = 1'b0, resetn = 1'b0;
    logic [5:0] ext_int = '0;
    logic wb_valid = 1'b0, wb_ex = 1'b0, wb_bd = 1'b0, wb_eret = 1'b0, mtc0_op = 1'b0;
    logic [4:0] wb_exccode = '0;
    logic [31:0] wb_pc = '0, wb_badvaddr = '0, c0_wdata = '0;
    logic [7:0] c0_addr = '0;
    logic [31:0] c0_rdata, flush_pc;
    logic flush, has_int;
    int checks = 0, errors = 0, edges = 0;
    logic m_bev, m_exl, m_ie, m_bd;
    logic [7:0] m_im;
    logic [1:0] m_ipsw;
    logic [4:0] m_exc;
    logic [31:0] m_epc, m_badv, m_cbase;
    int m_ccyc;

    cp0_unit #(.EXT_INT_W(6), .COUNT_DIV(DIV), .VEC_BEV1(V1), .VEC_BEV0(V0)) dut (
        .clk(clk), .resetn(resetn), .ext_int(ext_int), .wb_valid(wb_valid), .wb_ex(wb_ex),
        .wb_exccode(wb_exccode), .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .wb_eret(wb_eret), .mtc0_op(mtc0_op), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_rdata(c0_rdata), .flush(flush), .flush_pc(flush_pc), .has_int(has_int)
    );

    always #10 clk = ~clk;
    always @(posedge clk) if (resetn) edges++;

    // Count is the loaded value plus one per DIV cycles elapsed since the load
    function automatic logic [31:0] m_count();
        return m_cbase + 32'((edges - m_ccyc) / DIV);
    endfunction
    function automatic logic [31:0] m_status();
        return {9'b0, m_bev, 6'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction
    function automatic logic [31:0] m_cause(input logic t);
        return {m_bd, t, 14'b0, 6'b0, m_ipsw, 1'b0, m_exc, 2'b0};
    endfunction

    task automatic model_reset();
        m_bev = 1'b1; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_im = '0; m_ipsw = '0;
        m_exc = '0; m_epc = '0; m_badv = '0; m_cbase = '0; m_ccyc = edges;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        c0_addr = a;
        #1;
        d = c0_rdata;
    endtask

    task automatic step(input logic v, ex, input logic [4:0] code, input logic bdi,
                        input logic [31:0] pc, bva, input logic er, mt,
                        input logic [7:0] a, input logic [31:0] w);
        logic exc, ere, we;
        logic [31:0] pc_exp;
        @(negedge clk);
        wb_valid = v; wb_ex = ex; wb_exccode = code; wb_bd = bdi; wb_pc = pc;
        wb_badvaddr = bva; wb_eret = er; mtc0_op = mt; c0_addr = a; c0_wdata = w;
        exc = v & ex;
        ere = v & er & ~ex;
        we  = v & mt & ~ex;
        pc_exp = ere ? m_epc : (m_bev ? V1 : V0);
        #1;
        checks++;
        if (flush !== (exc | ere)) begin errors++; $display("FAIL flush got %b exp %b", flush, exc | ere); end
        checks++;
        if (flush_pc !== pc_exp) begin errors++; $display("FAIL flush_pc got %h exp %h", flush_pc, pc_exp); end
        @(posedge clk);
        #1;
        if (exc) begin
            if (!m_exl) begin m_bd = bdi; m_epc = bdi ? pc - 32'd4 : pc; end
            m_exc = code;
            m_exl = 1'b1;
            if (code == EX_ADEL || code == EX_ADES) m_badv = bva;
        end else if (ere) m_exl = 1'b0;
        if (we && a == CR_STATUS) begin
            m_bev = w[22]; m_im = w[15:8]; m_ie = w[0];
            if (!ere) m_exl = w[1];
        end
        if (we && a == CR_CAUSE) m_ipsw = w[9:8];
        if (we && a == CR_EPC) m_epc = w;
        if (we && a == CR_COUNT) begin m_cbase = w; m_ccyc = edges; end
        wb_valid = 1'b0; wb_ex = 1'b0; wb_eret = 1'b0; mtc0_op = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask
    task automatic mtc(input logic [7:0] a, input logic [31:0] w);
        step(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, a, w);
    endtask
    task automatic exc_(input logic [4:0] code, input logic bdi, input logic [31:0] pc, bva);
        step(1'b1, 1'b1, code, bdi, pc, bva, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask
    task automatic eret_();
        step(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        #1;
        rd(CR_STATUS, d);
        checks++; if (d !== 32'h00400000) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h00400000); end
        rd(CR_CAUSE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", d); end
        rd(CR_EPC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", d); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
        checks++; if (flush_pc !== 32'hbfc00380) begin errors++; $display("FAIL reset_flush_pc got %h exp bfc00380", flush_pc); end
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL reset_has_int got %b exp 0", has_int); end
        repeat (2) @(posedge clk);
        #1;
        rd(CR_COUNT, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL reset_count got %h exp 1", d); end
    endtask

    task automatic test_delay_slot();
        logic [31:0] d;
        exc_(EX_ADEL, 1'b1, 32'h80000104, 32'h00001235);
        rd(CR_EPC, d);
        checks++; if (d !== 32'h80000100) begin errors++; $display("FAIL ds_epc got %h exp 80000100", d); end
        rd(CR_CAUSE, d);
        checks++; if (d[31] !== 1'b1 || d[6:2] !== 5'd4) begin errors++; $display("FAIL ds_cause got %h exp bd=1 exc=4", d); end
        rd(CR_BADVADDR, d);
        checks++; if (d !== 32'h00001235) begin errors++; $display("FAIL ds_badvaddr got %h exp 1235", d); end
        rd(CR_STATUS, d);
        checks++; if (d[1] !== 1'b1) begin errors++; $display("FAIL ds_exl got %b exp 1", d[1]); end
        exc_(EX_SYS, 1'b0, 32'h80000200, 32'h0);
        rd(CR_EPC, d);
        checks++; if (d !== 32'h80000100) begin errors++; $display("FAIL nested_epc got %h exp 80000100", d); end
    endtask

    task automatic test_eret_bev();
        logic [31:0] d;
        eret_();
        rd(CR_STATUS, d);
        checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got %b exp 0", d[1]); end
        mtc(CR_STATUS, 32'h0);
        exc_(EX_OV, 1'b0, 32'h80000300, 32'h0);
        eret_();
    endtask

    task automatic test_timer();
        logic [31:0] d;
        mtc(CR_COUNT, 32'd0);
        mtc(CR_COMPARE, 32'd3);
        mtc(CR_STATUS, 32'h00008001);
        repeat (3) idle();
        rd(CR_COUNT, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL timer_count2 got %h exp 2", d); end
        rd(CR_CAUSE, d);
        checks++; if (d[30] !== 1'b0) begin errors++; $display("FAIL timer_early_ti got %b exp 0", d[30]); end
        idle();
        rd(CR_COUNT, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL timer_count3 got %h exp 3", d); end
        rd(CR_CAUSE, d);
        checks++; if (d[30] !== 1'b1 || d[15] !== 1'b1) begin errors++; $display("FAIL timer_ti got %h exp ti=1 ip7=1", d); end
        checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL timer_has_int got %b exp 1", has_int); end
        mtc(CR_COUNT, 32'd0);
        repeat (5) idle();
        mtc(CR_COMPARE, 32'd3);
        rd(CR_COUNT, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL timer_match_count got %h exp 3", d); end
        rd(CR_CAUSE, d);
        checks++; if (d[30] !== 1'b0) begin errors++; $display("FAIL timer_clear_ti got %b exp 0", d[30]); end
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL timer_clear_int got %b exp 0", has_int); end
    endtask

    task automatic test_ext_int();
        logic [31:0] d;
        logic [3:0] exp_seq;
        exp_seq = 4'b0100;
        mtc(CR_STATUS, 32'h00000401);
        @(negedge clk);
        ext_int = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (has_int !== exp_seq[i]) begin errors++; $display("FAIL ext_int_cycle%0d got %b exp %b", i + 1, has_int, exp_seq[i]); end
            ext_int = 6'b0;
        end
        mtc(CR_STATUS, 32'h00000101);
        mtc(CR_CAUSE, 32'h00000100);
        rd(CR_CAUSE, d);
        checks++; if (d[8] !== 1'b1) begin errors++; $display("FAIL sw_ip0 got %b exp 1", d[8]); end
        checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL sw_has_int got %b exp 1", has_int); end
        mtc(CR_CAUSE, 32'h0);
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL sw_clear got %b exp 0", has_int); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        step(1'b1, 1'b1, EX_SYS, 1'b0, 32'h80000400, 32'h0, 1'b0, 1'b1, CR_EPC, 32'hdeadbeef);
        rd(CR_EPC, d);
        checks++; if (d !== 32'h80000400) begin errors++; $display("FAIL prio_epc got %h exp 80000400", d); end
        eret_();
    endtask

    task automatic test_random();
        logic [7:0] addrs [4] = '{CR_STATUS, CR_CAUSE, CR_EPC, CR_COUNT};
        logic [4:0] codes [6] = '{EX_INT, EX_ADEL, EX_ADES, EX_SYS, EX_RI, EX_OV};
        logic [31:0] d, pc, w;
        logic v, ex, er, mt, bdi;
        logic [4:0] code;
        logic [7:0] a;
        int k;
        mtc(CR_COMPARE, 32'd0);
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 5));
            v = 1'b1; ex = 1'b0; er = 1'b0; mt = 1'b0; a = 8'd0;
            code = codes[$urandom_range(0, 5)];
            bdi = 1'($urandom_range(0, 1));
            pc = $urandom & 32'hfffffffc;
            w = $urandom;
            if (k == 0) ex = 1'b1;
            else if (k == 1) er = 1'b1;
            else if (k <= 3) begin mt = 1'b1; a = addrs[$urandom_range(0, 3)]; end
            else if (k == 4) begin
                v = 1'b0; ex = 1'($urandom_range(0, 1)); er = 1'($urandom_range(0, 1));
                mt = 1'($urandom_range(0, 1)); a = 8'($urandom);
            end else begin ex = 1'b1; mt = 1'b1; a = CR_EPC; end
            if (a == CR_COUNT) w = $urandom_range(16, 100000);
            step(v, ex, code, bdi, pc, $urandom, er, mt, a, w);
            rd(CR_STATUS, d);
            checks++; if (d !== m_status()) begin errors++; $display("FAIL rnd%0d_status got %h exp %h", n, d, m_status()); end
            rd(CR_CAUSE, d);
            checks++; if (d !== m_cause(1'b0)) begin errors++; $display("FAIL rnd%0d_cause got %h exp %h", n, d, m_cause(1'b0)); end
            rd(CR_EPC, d);
            checks++; if (d !== m_epc) begin errors++; $display("FAIL rnd%0d_epc got %h exp %h", n, d, m_epc); end
            rd(CR_BADVADDR, d);
            checks++; if (d !== m_badv) begin errors++; $display("FAIL rnd%0d_badvaddr got %h exp %h", n, d, m_badv); end
            rd(CR_COUNT, d);
            checks++; if (d !== m_count()) begin errors++; $display("FAIL rnd%0d_count got %h exp %h", n, d, m_count()); end
            checks++;
            if (has_int !== (|(m_ipsw & m_im[1:0]) & m_ie & ~m_exl)) begin
                errors++; $display("FAIL rnd%0d_has_int got %b exp %b", n, has_int, |(m_ipsw & m_im[1:0]) & m_ie & ~m_exl);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        mtc(CR_EPC, 32'h00001234);
        mtc(CR_STATUS, 32'h0000ff03);
        repeat (3) idle();
        rd(CR_COUNT, d);
        checks++; if (d !== m_count()) begin errors++; $display("FAIL pre_reset_count got %h exp %h", d, m_count()); end
        @(negedge clk);
        #3;
        resetn = 1'b0;
        #1;
        rd(CR_COUNT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL areset_count got %h exp 0", d); end
        rd(CR_STATUS, d);
        checks++; if (d !== 32'h00400000) begin errors++; $display("FAIL areset_status got %h exp 00400000", d); end
        rd(CR_EPC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL areset_epc got %h exp 0", d); end
        checks++; if (flush_pc !== V1) begin errors++; $display("FAIL areset_flush_pc got %h exp %h", flush_pc, V1); end
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL areset_has_int got %b exp 0", has_int); end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_delay_slot();
        test_eret_bev();
        test_timer();
        test_ext_int();
        test_priority();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
